// File: rtl/bp_io_wormhole_arbiter_pkg.sv
// Shared constants for the IO NoC wormhole arbiter: controller state encodings
// and a width helper that stays legal for single-entry selects.
package bp_io_wormhole_arbiter_pkg;

  localparam logic [0:0] e_idle   = 1'b0;
  localparam logic [0:0] e_locked = 1'b1;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_io_rr_picker.sv
// Combinational round-robin picker: first valid requester after rr_last_i,
// returned both one-hot and encoded.
module bp_io_rr_picker
  import bp_io_wormhole_arbiter_pkg::*;
#(
  parameter int num_in_p = 2,
  localparam int lg_in_lp = safe_clog2(num_in_p)
) (
  input  logic [num_in_p-1:0] v_i,
  input  logic [lg_in_lp-1:0] rr_last_i,
  output logic [num_in_p-1:0] grant_o,
  output logic [lg_in_lp-1:0] sel_o
);

  logic [lg_in_lp-1:0] idx;
  logic                found;

  always_comb begin
    grant_o = '0;
    sel_o   = '0;
    idx     = '0;
    found   = 1'b0;
    // Offsets 1..num_in_p so the last winner is considered last.
    for (int k = 1; k <= num_in_p; k++) begin
      idx = lg_in_lp'((int'(rr_last_i) + k) % num_in_p);
      if (!found && v_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        sel_o        = idx;
      end
    end
  end

endmodule

// File: rtl/bp_io_wormhole_arbiter.sv
// Packet-granular round-robin merge of several IO NoC flit streams onto one
// egress link; a header with nonzero length locks the grant until its last body flit.
//
// state    | meaning
// e_idle   | picker chooses a valid input; next handshake is a header
// e_locked | grant pinned to lock_id until body_cnt body flits have transferred
module bp_io_wormhole_arbiter
  import bp_io_wormhole_arbiter_pkg::*;
#(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  localparam int lg_in_lp    = safe_clog2(num_in_p)
) (
  input  logic                         clk_i,
  input  logic                         async_reset_n_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  input  logic [num_in_p-1:0]          v_i,
  output logic [num_in_p-1:0]          ready_and_o,
  output logic [flit_width_p-1:0]      data_o,
  output logic                         v_o,
  input  logic                         ready_and_i,
  output logic [num_in_p-1:0]          grant_o,
  output logic                         locked_o
);

  logic [0:0]             state_q, state_d;
  logic [lg_in_lp-1:0]    lock_id_q, lock_id_d;
  logic [len_width_p-1:0] body_cnt_q, body_cnt_d;
  logic [lg_in_lp-1:0]    rr_last_q, rr_last_d;

  logic [num_in_p-1:0]    pick_grant;
  logic [lg_in_lp-1:0]    pick_sel;
  logic [num_in_p-1:0]    grant;
  logic [lg_in_lp-1:0]    sel;
  logic [flit_width_p-1:0] flit;
  logic                   flit_v;
  logic                   hs;
  logic [len_width_p-1:0] hdr_len;

  bp_io_rr_picker #(
    .num_in_p(num_in_p)
  ) picker (
    .v_i      (v_i),
    .rr_last_i(rr_last_q),
    .grant_o  (pick_grant),
    .sel_o    (pick_sel)
  );

  always_comb begin
    sel   = pick_sel;
    grant = pick_grant;
    if (state_q == e_locked) begin
      sel            = lock_id_q;
      grant          = '0;
      grant[lock_id_q] = 1'b1;
    end
  end

  always_comb begin
    flit = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (grant[k]) flit = data_i[k*flit_width_p +: flit_width_p];
    end
  end

  assign flit_v  = |(grant & v_i);
  assign hs      = flit_v & ready_and_i;
  assign hdr_len = flit[cord_width_p +: len_width_p];

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    body_cnt_d = body_cnt_q;
    rr_last_d  = rr_last_q;
    if (hs) begin
      if (state_q == e_idle) begin
        rr_last_d = sel;
        if (hdr_len != '0) begin
          state_d    = e_locked;
          lock_id_d  = sel;
          body_cnt_d = hdr_len;
        end
      end else if (body_cnt_q == len_width_p'(1)) begin
        state_d    = e_idle;
        body_cnt_d = '0;
      end else begin
        body_cnt_d = body_cnt_q - len_width_p'(1);
      end
    end
  end

  // rr_last resets to the top index so input 0 is first in line.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q    <= e_idle;
      lock_id_q  <= '0;
      body_cnt_q <= '0;
      rr_last_q  <= lg_in_lp'(num_in_p - 1);
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      body_cnt_q <= body_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign data_o      = flit;
  assign v_o         = flit_v & async_reset_n_i;
  assign ready_and_o = grant & {num_in_p{ready_and_i & async_reset_n_i}};
  assign grant_o     = grant & {num_in_p{async_reset_n_i}};
  assign locked_o    = (state_q == e_locked) & async_reset_n_i;

endmodule

// File: tb/tb_bp_io_wormhole_arbiter.sv
// Scoreboard bench for bp_io_wormhole_arbiter: per-input source queues feed the
// DUT, expected egress flits are queued at load time and popped on each handshake.
module tb_bp_io_wormhole_arbiter;

  localparam int num_in_p     = 2;
  localparam int flit_width_p = 64;
  localparam int cord_width_p = 8;
  localparam int len_width_p  = 4;

  logic                             clk_i = 1'b0;
  logic                             async_reset_n_i;
  logic [num_in_p*flit_width_p-1:0] data_i;
  logic [num_in_p-1:0]              v_i;
  logic [num_in_p-1:0]              ready_and_o;
  logic [flit_width_p-1:0]          data_o;
  logic                             v_o;
  logic                             ready_and_i;
  logic [num_in_p-1:0]              grant_o;
  logic                             locked_o;

  bp_io_wormhole_arbiter #(
    .num_in_p    (num_in_p),
    .flit_width_p(flit_width_p),
    .cord_width_p(cord_width_p),
    .len_width_p (len_width_p)
  ) dut (
    .clk_i          (clk_i),
    .async_reset_n_i(async_reset_n_i),
    .data_i         (data_i),
    .v_i            (v_i),
    .ready_and_o    (ready_and_o),
    .data_o         (data_o),
    .v_o            (v_o),
    .ready_and_i    (ready_and_i),
    .grant_o        (grant_o),
    .locked_o       (locked_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp;
  int n_mis;
  int n_hs;
  int pkt_id;
  logic [63:0] src_q[num_in_p][$];
  logic [63:0] exp_q[$];
  logic [num_in_p-1:0] hold;
  logic [num_in_p-1:0] hs;
  logic force_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Flit layout: [63:56] source, [55:32] packet id, [31:16] flit index, [11:8] len, [7:0] cord.
  function automatic logic [63:0] mk_flit(input int src, input int pkt, input int idx, input int len);
    return {8'(src), 24'(pkt), 16'(idx), 4'h0, 4'(len), 8'hc0};
  endfunction

  task automatic send_pkt(input int src, input int len);
    logic [63:0] f;
    for (int i = 0; i <= len; i++) begin
      f = mk_flit(src, pkt_id, i, (i == 0) ? len : 0);
      src_q[src].push_back(f);
      exp_q.push_back(f);
    end
    pkt_id++;
  endtask

  task automatic update_drv();
    for (int k = 0; k < num_in_p; k++) begin
      v_i[k] = force_v | ((src_q[k].size() > 0) & ~hold[k]);
      data_i[k*flit_width_p +: flit_width_p] = (src_q[k].size() > 0) ? src_q[k][0] : 64'h0;
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    logic [num_in_p-1:0] eg;
    for (int k = 0; k < num_in_p; k++) hs[k] = v_i[k] & ready_and_o[k];
    if (v_o && ready_and_i) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        chk("extra_flit", 64'(exp_q.size()), 64'd1);
      end else begin
        e  = exp_q.pop_front();
        eg = num_in_p'(1) << e[63:56];
        chk("data", data_o, e);
        chk("grant", 64'(grant_o), 64'(eg));
        chk("locked", 64'(locked_o), 64'(e[31:16] != 16'd0));
        chk("ready", 64'(ready_and_o), 64'(eg));
      end
    end
  endtask

  // Inputs are always settled before the negedge that samples them.
  task automatic cycle();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < num_in_p; k++) begin
      if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    hs = '0;
    update_drv();
  endtask

  task automatic run_drain(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      busy = (exp_q.size() != 0);
      for (int k = 0; k < num_in_p; k++) if (src_q[k].size() != 0) busy = 1'b1;
      if (busy) begin
        cycle();
        n++;
      end
    end
    if (busy) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      for (int k = 0; k < num_in_p; k++) src_q[k].delete();
      update_drv();
    end
  endtask

  logic [63:0] body_flit;
  int hs_base;

  initial begin
    n_cmp = 0; n_mis = 0; n_hs = 0; pkt_id = 0;
    hold = '0; hs = '0; force_v = 1'b1;
    async_reset_n_i = 1'b0;
    ready_and_i = 1'b1;
    data_i = '0;
    update_drv();

    // Reset with every input valid.
    #12;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_ready", 64'(ready_and_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_locked", 64'(locked_o), 64'd0);
    @(posedge clk_i);
    #1;
    async_reset_n_i = 1'b1;
    force_v = 1'b0;
    send_pkt(0, 0); send_pkt(1, 0); send_pkt(0, 0); send_pkt(1, 0);
    update_drv();
    run_drain(20);

    // Wormhole lock with in1 contending throughout.
    send_pkt(0, 3); send_pkt(1, 0);
    update_drv();
    run_drain(20);

    // Bubble inside a locked packet.
    send_pkt(0, 2); send_pkt(1, 0);
    update_drv();
    cycle();
    hold[0] = 1'b1;
    update_drv();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bubble_v_o", 64'(v_o), 64'd0);
      chk("bubble_grant", 64'(grant_o), 64'd1);
      chk("bubble_locked", 64'(locked_o), 64'd1);
      cycle();
    end
    hold[0] = 1'b0;
    update_drv();
    run_drain(20);

    // Downstream stall mid-packet.
    hs_base = n_hs;
    body_flit = mk_flit(1, pkt_id, 1, 0);
    send_pkt(1, 1);
    update_drv();
    cycle();
    ready_and_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_data", data_o, body_flit);
      chk("stall_v_o", 64'(v_o), 64'd1);
      chk("stall_locked", 64'(locked_o), 64'd1);
      chk("stall_ready", 64'(ready_and_o), 64'd0);
      cycle();
    end
    ready_and_i = 1'b1;
    run_drain(20);
    chk("stall_hs_count", 64'(n_hs - hs_base), 64'd2);
    #2;
    chk("stall_unlocked", 64'(locked_o), 64'd0);

    // Maximum length packet, then in1 must win.
    hs_base = n_hs;
    send_pkt(0, 15); send_pkt(1, 0);
    update_drv();
    run_drain(60);
    chk("maxlen_hs_count", 64'(n_hs - hs_base), 64'd17);
    #2;
    chk("maxlen_unlocked", 64'(locked_o), 64'd0);

    // Reset in the middle of a packet.
    send_pkt(0, 5); send_pkt(1, 0);
    update_drv();
    cycle();
    cycle();
    #1;
    chk("mid_locked", 64'(locked_o), 64'd1);
    async_reset_n_i = 1'b0;
    force_v = 1'b1;
    exp_q.delete();
    for (int k = 0; k < num_in_p; k++) src_q[k].delete();
    hs = '0;
    update_drv();
    #1;
    chk("mid_rst_v_o", 64'(v_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_and_o), 64'd0);
    chk("mid_rst_grant", 64'(grant_o), 64'd0);
    chk("mid_rst_locked", 64'(locked_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    async_reset_n_i = 1'b1;
    force_v = 1'b0;
    update_drv();
    #1;
    chk("post_rst_locked", 64'(locked_o), 64'd0);
    send_pkt(0, 0); send_pkt(1, 0);
    update_drv();
    run_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
